// File: rtl/led_debug_sequencer_if.sv
// LED sequencer bundle: code handshake from the requester
// plus the Avalon-MM write port toward the LED PIO.
interface led_debug_sequencer_if;
  logic        hb_enable;
  logic        code_valid;
  logic [3:0]  code;
  logic        code_ready;
  logic        busy;
  logic [2:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  modport master (
    input  hb_enable,
    input  code_valid,
    input  code,
    output code_ready,
    output busy,
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata
  );

  modport slave (
    output hb_enable,
    output code_valid,
    output code,
    input  code_ready,
    input  busy,
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata
  );
endinterface

// File: rtl/led_debug_sequencer.sv
// Debug LED sequencer: idle heartbeat plus N-pulse blink codes,
// driving the LED PIO set/clear registers over Avalon-MM.
module led_debug_sequencer #(
  parameter int CNT_W     = 26,
  parameter int HB_HALF   = 25000000,
  parameter int PULSE_ON  = 10000000,
  parameter int PULSE_OFF = 10000000,
  parameter int GAP       = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  led_debug_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP
  } state_e;

  localparam logic [CNT_W-1:0] HB_LD  = CNT_W'(HB_HALF - 1);
  localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(PULSE_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(PULSE_OFF - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             hb_q, hb_d;
  logic [3:0]       pulses_q, pulses_d;
  logic             hb_en_q;
  logic             cs_q, cs_d;
  logic             wn_q, wn_d;
  logic [2:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             wr_set, wr_clr;
  logic             expired;

  assign expired = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= HB_LD;
      hb_q     <= 1'b0;
      pulses_q <= 4'd0;
      hb_en_q  <= 1'b0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= 3'd0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      hb_q     <= hb_d;
      pulses_q <= pulses_d;
      hb_en_q  <= bus.hb_enable;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    hb_d     = hb_q;
    pulses_d = pulses_q;
    wr_set   = 1'b0;
    wr_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // a new code pre-empts any heartbeat action this cycle
        if (bus.code_valid) begin
          pulses_d = bus.code;
          hb_d     = 1'b0;
          if (bus.code != 4'd0) begin
            state_d = S_ON;
            timer_d = ON_LD;
            wr_set  = 1'b1;
          end else begin
            state_d = S_GAP;
            timer_d = GAP_LD;
            wr_clr  = 1'b1;
          end
        end else if (hb_en_q && !bus.hb_enable) begin
          wr_clr  = 1'b1;
          hb_d    = 1'b0;
          timer_d = HB_LD;
        end else if (bus.hb_enable) begin
          if (expired) begin
            hb_d    = !hb_q;
            timer_d = HB_LD;
            wr_set  = !hb_q;
            wr_clr  = hb_q;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      S_ON: begin
        if (expired) begin
          state_d  = S_OFF;
          timer_d  = OFF_LD;
          pulses_d = pulses_q - 4'd1;
          wr_clr   = 1'b1;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      S_OFF: begin
        if (expired) begin
          if (pulses_q != 4'd0) begin
            state_d = S_ON;
            timer_d = ON_LD;
            wr_set  = 1'b1;
          end else begin
            state_d = S_GAP;
            timer_d = GAP_LD;
          end
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      S_GAP: begin
        if (expired) begin
          state_d = S_IDLE;
          timer_d = HB_LD;
          hb_d    = 1'b0;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cs_d   = wr_set | wr_clr;
    wn_d   = !(wr_set | wr_clr);
    addr_d = wr_set ? 3'd4 : (wr_clr ? 3'd5 : 3'd0);
    data_d = (wr_set | wr_clr) ? 32'h1 : 32'h0;
    bus.code_ready     = (state_q == S_IDLE);
    bus.busy           = (state_q != S_IDLE);
    bus.pio_chipselect = cs_q;
    bus.pio_write_n    = wn_q;
    bus.pio_address    = addr_q;
    bus.pio_writedata  = data_q;
  end

endmodule

// File: tb/tb_led_debug_sequencer.sv
// Directed bench for led_debug_sequencer: logs every PIO write
// with its cycle number and checks timing against hand values.
module tb_led_debug_sequencer;

  typedef struct {
    int         t;
    logic [2:0] a;
  } wr_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   base;
  int   n_chk;
  int   n_err;
  int   bad_bus;
  int   busy_cyc;
  logic prev_cs;
  wr_t  log_q[$];

  led_debug_sequencer_if bus();

  led_debug_sequencer #(
    .CNT_W(8),
    .HB_HALF(5),
    .PULSE_ON(3),
    .PULSE_OFF(2),
    .GAP(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    bad_bus  = 0;
    busy_cyc = 0;
    prev_cs  = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.pio_chipselect) begin
      log_q.push_back('{t: cyc, a: bus.pio_address});
      if (bus.pio_address != 3'd4 && bus.pio_address != 3'd5)
        bad_bus++;
      if (bus.pio_writedata != 32'h1)
        bad_bus++;
      if (prev_cs)
        bad_bus++;
    end
    if (bus.pio_chipselect == bus.pio_write_n)
      bad_bus++;
    prev_cs = bus.pio_chipselect;
    if (bus.busy)
      busy_cyc++;
  end

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int wt(int i);
    return (i < log_q.size()) ? log_q[i].t - base : -1;
  endfunction

  function automatic int wa(int i);
    return (i < log_q.size()) ? int'(log_q[i].a) : -1;
  endfunction

  int same;
  int sets;

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.hb_enable = 1'b1;
    bus.code_valid = 1'b0;
    bus.code = 4'd0;
    run(3);
    chk("rst_ready", int'(bus.code_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cs", int'(bus.pio_chipselect), 0);
    chk("rst_wn", int'(bus.pio_write_n), 1);
    chk("rst_addr", int'(bus.pio_address), 0);
    chk("rst_data", int'(bus.pio_writedata), 0);

    // heartbeat out of reset
    reset_n = 1'b1;
    base = cyc;
    log_q.delete();
    run(16);
    chk("hb_n", log_q.size(), 3);
    chk("hb0_t", wt(0), 5);
    chk("hb0_a", wa(0), 4);
    chk("hb1_t", wt(1), 10);
    chk("hb1_a", wa(1), 5);
    chk("hb2_t", wt(2), 15);
    chk("hb2_a", wa(2), 4);

    // heartbeat disabled while LED on
    base = cyc;
    log_q.delete();
    bus.hb_enable = 1'b0;
    run(10);
    chk("hboff_n", log_q.size(), 1);
    chk("hboff_t", wt(0), 1);
    chk("hboff_a", wa(0), 5);
    base = cyc;
    log_q.delete();
    bus.hb_enable = 1'b1;
    run(6);
    chk("hbre_n", log_q.size(), 1);
    chk("hbre_t", wt(0), 5);
    chk("hbre_a", wa(0), 4);
    bus.hb_enable = 1'b0;
    run(5);

    // code 2
    base = cyc;
    log_q.delete();
    busy_cyc = 0;
    bus.code_valid = 1'b1;
    bus.code = 4'd2;
    run(1);
    chk("c2_ready", int'(bus.code_ready), 0);
    bus.code_valid = 1'b0;
    run(20);
    chk("c2_n", log_q.size(), 4);
    chk("c2_t0", wt(0), 1);
    chk("c2_a0", wa(0), 4);
    chk("c2_t1", wt(1), 4);
    chk("c2_a1", wa(1), 5);
    chk("c2_t2", wt(2), 6);
    chk("c2_a2", wa(2), 4);
    chk("c2_t3", wt(3), 9);
    chk("c2_a3", wa(3), 5);
    chk("c2_busy", busy_cyc, 14);
    chk("c2_ready_end", int'(bus.code_ready), 1);

    // code 0
    base = cyc;
    log_q.delete();
    busy_cyc = 0;
    bus.code_valid = 1'b1;
    bus.code = 4'd0;
    run(1);
    bus.code_valid = 1'b0;
    run(8);
    chk("c0_n", log_q.size(), 1);
    chk("c0_t", wt(0), 1);
    chk("c0_a", wa(0), 5);
    chk("c0_busy", busy_cyc, 4);

    // code 5 requested while code 1 is still running
    base = cyc;
    log_q.delete();
    bus.code_valid = 1'b1;
    bus.code = 4'd1;
    run(1);
    bus.code_valid = 1'b0;
    run(3);
    bus.code_valid = 1'b1;
    bus.code = 4'd5;
    run(1);
    chk("c5_held_ready", int'(bus.code_ready), 0);
    run(6);
    bus.code_valid = 1'b0;
    run(35);
    chk("c5_n", log_q.size(), 12);
    chk("c5_t1", wt(1), 4);
    chk("c5_acc_t", wt(2), 11);
    chk("c5_acc_a", wa(2), 4);
    same = 0;
    sets = 0;
    for (int i = 2; i < log_q.size(); i++) begin
      if (log_q[i].a == log_q[i-1].a)
        same++;
      if (log_q[i].a == 3'd4)
        sets++;
    end
    chk("c5_alt", same, 0);
    chk("c5_sets", sets, 5);
    chk("c5_ready_end", int'(bus.code_ready), 1);

    // reset in the middle of FLASH_ON
    base = cyc;
    log_q.delete();
    bus.code_valid = 1'b1;
    bus.code = 4'd3;
    run(1);
    bus.code_valid = 1'b0;
    run(1);
    reset_n = 1'b0;
    run(1);
    chk("mr_cs", int'(bus.pio_chipselect), 0);
    chk("mr_ready", int'(bus.code_ready), 1);
    chk("mr_busy", int'(bus.busy), 0);
    reset_n = 1'b1;
    run(20);
    chk("mr_n", log_q.size(), 1);
    chk("mr_t", wt(0), 1);

    chk("bus_protocol", bad_bus, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/led_debug_sequencer.md
Name: led_debug_sequencer

Overview:
- Avalon-MM write master that drives the single-bit debug LED PIO slave through its data, set and clear registers.
- Two functions: an idle heartbeat toggle, and an error/status blink code of N pulses followed by a gap.
- Sits beside the Nios II data master in the Qsys system, or in front of the LED PIO via a local port. Firmware or hardware posts a 4-bit code with a valid/ready handshake; the sequencer owns all LED timing.

Parameters:
- CNT_W, 26, width of the shared down-counter timer.
- HB_HALF, 25000000, heartbeat half-period in clk cycles (≥2).
- PULSE_ON, 10000000, LED-on cycles per code pulse (≥2).
- PULSE_OFF, 10000000, LED-off cycles between pulses (≥2).
- GAP, 50000000, LED-off cycles after the last pulse, before heartbeat resumes (≥2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- hb_enable  in  1  heartbeat enable while idle
- code_valid  in  1  code request
- code  in  4  pulse count 0..15
- code_ready  out  1  high only in IDLE
- busy  out  1  high in any non-IDLE state
- pio_address  out  3  PIO register address (0 data, 4 set, 5 clear)
- pio_chipselect  out  1  PIO chipselect
- pio_write_n  out  1  PIO write strobe, active low
- pio_writedata  out  32  PIO write data

Behaviour:
- Reset and timing:
  - Only clk is used. reset_n is sampled on the rising edge.
  - Reset values: state IDLE, timer=HB_HALF-1, hb_level=0, pulses=0, hb_en_q=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
  - Reset mid-sequence abandons the sequence with no further write. The PIO's own reset clears the LED.
- Bus outputs:
  - All bus outputs are registered.
  - A "write" is exactly one cycle of chipselect=1, write_n=0. It appears in the cycle after the edge that decided it. Every other cycle has chipselect=0, write_n=1.
  - set = address 4, data 32'h1. clear = address 5, data 32'h1. Writes never use address 0.
  - No waitrequest: the slave accepts every write in one cycle.
  - LED changes one cycle after the write cycle.
- Handshake:
  - Accept when code_valid && code_ready at an edge. code is captured into pulses.
  - code_valid while busy is ignored, not queued. The requester holds code_valid until code_ready is high.
- Timer:
  - Each timed state lasts exactly its parameter value in cycles.
  - The timer is loaded with value-1 on entry and the state expires when the timer reads 0.
- IDLE:
  - If hb_enable=1, timer counts down. At 0: toggle hb_level, reload HB_HALF-1, issue set if the new hb_level=1, else clear.
  - On hb_enable falling (hb_en_q=1, hb_enable=0): issue clear, hb_level<=0, timer<=HB_HALF-1.
  - While hb_enable=0 the timer holds.
  - Accept has priority over a heartbeat expiry in the same cycle: no heartbeat write that cycle.
- Accept with code≠0:
  - → FLASH_ON, issue set, timer<=PULSE_ON-1.
  - hb_level<=0.
- Accept with code=0:
  - → GAP, issue clear, timer<=GAP-1.
- FLASH_ON expiry:
  - Issue clear, pulses<=pulses-1, → FLASH_OFF, timer<=PULSE_OFF-1.
- FLASH_OFF expiry:
  - If pulses≠0: issue set, → FLASH_ON, timer<=PULSE_ON-1.
  - Else → GAP, timer<=GAP-1, no write.
- GAP expiry:
  - → IDLE, timer<=HB_HALF-1, hb_level=0, no write.
  - The heartbeat restarts from LED off.
- hb_enable is ignored outside IDLE. hb_en_q is updated every cycle.
- Code 15 produces 15 set and 15 clear writes in strict alternation. The write pattern is never two sets or two clears in a row within a code.

Test Plan:
(Params HB_HALF=5, PULSE_ON=3, PULSE_OFF=2, GAP=4, CNT_W=8.)
- Reset, hb_enable=1, no code -> first write is set@4 in cycle 6 after reset release; then clear@5 and set alternating every 5 cycles; chipselect high exactly 1 cycle each.
- Idle, hb_enable=0, pulse code_valid with code=2 -> ready drops next cycle; writes set, clear(+3), set(+5), clear(+8); busy for 3+2+3+2+4=14 cycles; code_ready high again after; no heartbeat write before a further 5 idle cycles.
- code=0 accepted -> single clear write, busy exactly 4 cycles, no set writes.
- Assert code_valid with code=5 while busy in FLASH_OFF -> no accept; held valid accepted on first IDLE cycle; captured code=5 gives 5 set writes.
- hb_enable 1→0 while LED on -> one clear write next cycle, no further writes while disabled; re-enable -> set after 5 cycles.
- reset_n low for 1 cycle during FLASH_ON of code=3 -> bus idle from next cycle, state IDLE, code_ready=1, no residual writes.
